transition_pattern_tx: RTL and testbench



---
 rtl/transition_pattern_tx.sv | 115 +++++++++++
 tb/tb_transition_pattern_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/transition_pattern_tx.sv
// transition_pattern_tx: serial line driver for the 2-bit change-detect link.
//
// A parallel word of change flags (Din, bit 0 first) is sent as a 1-bit
// stream X that toggles for each 1-flag and holds for each 0-flag. Each frame
// starts with one seed bit at level SEED. A downstream detector that compares
// adjacent line bits therefore recovers the flags one per cycle.
//
// Optional build macro: TX_PARITY_EN
//   When defined, one extra bit is appended after data bit WIDTH-1. Its
//   change flag is the XOR of all captured flags, so every frame contains an
//   even number of toggles. Valid then lasts WIDTH+2 cycles instead of WIDTH+1.
//
// Load/Ready handshake:
//   A frame is accepted on a rising Clk edge where Load=1 and Ready=1. Ready is
//   combinational and is high exactly while the FSM is IDLE, including the
//   Done cycle, so frames can run back to back. Din is sampled only at the
//   accepting edge. Load while Ready=0 is dropped and is not remembered.
//
// dbg_state exposes the FSM encoding: 0=IDLE, 1=SEED, 2=SHIFT.

module transition_pattern_tx #(
  parameter int   WIDTH = 8,
  parameter logic SEED  = 1'b0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic             Ready,
  output logic             X,
  output logic             Valid,
  output logic             Done,
  output logic [1:0]       dbg_state
);

  // Number of flag bits shifted out after the seed bit.
`ifdef TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  // The counter reaches NBITS at most (WIDTH+1 with parity), so it never wraps.
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(NBITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEED  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t           state;
  logic [NBITS-1:0] sh;
  logic [CW-1:0]    cnt;

  // Ready is a pure decode of the state register.
  assign Ready     = (state == S_IDLE);
  assign dbg_state = state;

  // Frame sequencer: captures flags, drives the seed, then one flag per edge.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state <= S_IDLE;
      X     <= SEED;
      Valid <= 1'b0;
      Done  <= 1'b0;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      // Done is a single-cycle pulse; only the frame-end edge raises it.
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          // X keeps its last level while idle.
          if (Load) begin
`ifdef TX_PARITY_EN
            sh <= {^Din, Din};
`else
            sh <= Din;
`endif
            X     <= SEED;
            Valid <= 1'b1;
            cnt   <= '0;
            state <= S_SEED;
          end
        end
        S_SEED: begin
          // Seed bit is on the line this cycle; the edge drives data bit 0.
          X     <= X ^ sh[0];
          sh    <= sh >> 1;
          cnt   <= CW'(1);
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          // cnt equals the number of flag bits already placed on the line.
          if (cnt == LAST) begin
            Valid <= 1'b0;
            Done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            X   <= X ^ sh[0];
            sh  <= sh >> 1;
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transition_pattern_tx.sv
// tb_transition_pattern_tx: directed frames with hand-computed line sequences.
// The driver pushes expected line bits into exp_q; the monitor pops on every
// Valid cycle and checks X, the recovered flag, Done timing and Ready.

module tb_transition_pattern_tx;

  localparam int WIDTH = 8;
`ifdef TX_PARITY_EN
  localparam int NB = WIDTH + 2;
`else
  localparam int NB = WIDTH + 1;
`endif

  // Clock / reset block
  logic             Clk = 1'b0;
  logic             Clr = 1'b1;
  logic             Load = 1'b0;
  logic [WIDTH-1:0] Din = '0;
  logic             Ready, X, Valid, Done;
  logic [1:0]       dbg_state;

  always #5 Clk = ~Clk;

  transition_pattern_tx #(.WIDTH(WIDTH), .SEED(1'b0)) dut (
    .Clk(Clk), .Clr(Clr), .Load(Load), .Din(Din),
    .Ready(Ready), .X(X), .Valid(Valid), .Done(Done), .dbg_state(dbg_state)
  );

  // Scoreboard state. Entry bits: {last, has_flag, flag, x}.
  logic [3:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic       mon_en = 1'b0;
  logic       exp_done = 1'b0;
  logic       prev_x = 1'b0;

  task automatic check(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    logic [3:0] e;
    if (mon_en) begin
      check("done_pulse", Done, exp_done);
      exp_done = 1'b0;
      check("ready_vs_valid", Ready, ~Valid);
      if (Valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", Valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("line_x", X, e[0]);
          if (e[2]) check("detector_flag", X ^ prev_x, e[1]);
          if (e[3]) exp_done = 1'b1;
        end
      end
      prev_x = X;
    end
  end

  // Push one frame's expected line levels (xb bit i = cycle i, i=0 seed).
  task automatic push_frame(input logic [WIDTH-1:0] din, input logic [9:0] xb);
    for (int i = 0; i < NB; i++) begin
      logic f;
      f = (i == 0) ? 1'b0 : ((i <= WIDTH) ? din[i-1] : ^din);
      exp_q.push_back({(i == NB - 1), (i != 0), f, xb[i]});
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (Ready !== 1'b1 && g < 200) begin
      @(posedge Clk); #1;
      g++;
    end
    if (Ready !== 1'b1) check("ready_timeout", Ready, 1'b1);
  endtask

  // Driver: present a frame for one accepting edge, then scramble Din.
  task automatic send(input logic [WIDTH-1:0] din, input logic [9:0] xb);
    wait_ready();
    push_frame(din, xb);
    Load = 1'b1;
    Din  = din;
    @(posedge Clk); #1;
    Load = 1'b0;
    Din  = WIDTH'($urandom_range(0, 255));
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || Ready !== 1'b1) && g < 300) begin
      @(posedge Clk); #1;
      g++;
    end
    check("drain_timeout", exp_q.size() == 0, 1'b1);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  // Hand-computed line sequences, seed first. The parity bit, when built in,
  // stays at 0 for all four vectors, so only the frame length changes.
  localparam logic [9:0] X_A6 = 10'h0C4; // 0,0,1,0,0,0,1,1,0
  localparam logic [9:0] X_FF = 10'h0AA; // 0,1,0,1,0,1,0,1,0
  localparam logic [9:0] X_00 = 10'h000; // all 0
  localparam logic [9:0] X_01 = 10'h1FE; // 0,1,1,1,1,1,1,1,1

  initial begin
    // Reset
    Clr = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Clr = 1'b0;
    check("reset_x", X, 1'b0);
    check("reset_valid", Valid, 1'b0);
    check("reset_done", Done, 1'b0);
    check("reset_ready", Ready, 1'b1);
    mon_en = 1'b1;

    // Basic patterns
    send(8'hA6, X_A6);
    drain();
    send(8'hFF, X_FF);
    drain();
    send(8'h00, X_00);
    drain();

    // Back-to-back frames with Load held high
    push_frame(8'h01, X_01);
    push_frame(8'h01, X_01);
    Load = 1'b1;
    Din  = 8'h01;
    repeat (NB + 2) @(posedge Clk);
    #1;
    Load = 1'b0;
    Din  = 8'h00;
    // We are now in the seed cycle of the second frame.
    check("b2b_second_valid", Valid, 1'b1);
    check("b2b_second_seed", X, 1'b0);
    drain();

    // Load during SHIFT is ignored
    send(8'hA6, X_A6);
    repeat (3) @(posedge Clk);
    #1;
    Load = 1'b1;
    Din  = 8'hFF;
    @(posedge Clk); #1;
    Load = 1'b0;
    drain();

    // Clr while data bit 3 is on the line
    send(8'hA6, X_A6);
    repeat (4) @(posedge Clk);
    #1;
    check("mid_clr_busy", Ready, 1'b0);
    Clr = 1'b1;
    @(posedge Clk); #1;
    Clr = 1'b0;
    exp_q.delete();
    check("clr_x", X, 1'b0);
    check("clr_valid", Valid, 1'b0);
    check("clr_done", Done, 1'b0);
    check("clr_ready", Ready, 1'b1);
    send(8'hFF, X_FF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
